// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program image loader: FSM states, word format, defaults.
package prog_loader_pkg;

  localparam int DEFAULT_NUM_WORDS = 16;
  localparam int PROG_WORD_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    RX_HI,
    RX_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } ld_state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } prog_word_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, program-memory and status signals of the loader.
// master = byte source / memory / supervisor side, slave = prog_loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) ();

  logic                   start;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [PROG_WORD_W-1:0] mem_wdata;
  logic                   cpu_rstn;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, done, err
  );

endinterface

// File: rtl/prog_checksum.sv
// Modulo-256 byte accumulator; sum updates one cycle after add_en, clear has priority.
// No backpressure: the caller decides which bytes count.
module prog_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + byte_in;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a 2*NUM_WORDS byte image (high byte first) plus a checksum byte into program memory,
// one write cycle per word; byte_ready drops during WRITE and outside a load, so the source holds.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int ADDR_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  ld_state_t         state;
  logic [ADDR_W-1:0] word_cnt;
  logic [7:0]        hi_byte;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  prog_word_t        wdata_q;
  logic              cpu_rstn_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              xfer;
  logic              start_ok;
  logic              sum_add;
  logic [7:0]        sum;
  logic [7:0]        chk_total;

  assign xfer      = bus.byte_valid & ready_q;
  assign start_ok  = bus.start & ((state == IDLE) | (state == DONE) | (state == ERROR));
  assign sum_add   = xfer & ((state == RX_HI) | (state == RX_LO));
  // The trailing byte is chosen so that it brings the running sum to zero.
  assign chk_total = sum + bus.byte_in;

  prog_checksum u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .add_en  (sum_add),
    .byte_in (bus.byte_in),
    .sum     (sum)
  );

  // Outputs are updated on the transition into each state so they are plain flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      hi_byte    <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state      <= RX_HI;
            word_cnt   <= '0;
            ready_q    <= 1'b1;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        RX_HI: begin
          if (xfer) begin
            hi_byte <= bus.byte_in;
            state   <= RX_LO;
          end
        end
        RX_LO: begin
          if (xfer) begin
            state   <= WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= word_cnt;
            wdata_q <= '{hi: hi_byte, lo: bus.byte_in};
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          if (word_cnt == LAST_ADDR) begin
            state <= CHECK;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= RX_HI;
          end
        end
        CHECK: begin
          if (xfer) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (chk_total == 8'h00) begin
              state      <= DONE;
              done_q     <= 1'b1;
              cpu_rstn_q <= 1'b1;
            end else begin
              state <= ERROR;
              err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rstn   = cpu_rstn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of image loads plus random loads, checked against an image/sum model.
module tb_prog_loader;

  localparam int NW = 16;
  localparam int AW = 4;

  logic clk;
  logic rst;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;
  wr_t wr_q[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  logic [15:0] img[NW];

  typedef struct {
    string      name;
    bit         random_img;
    bit         gaps;
    bit         poke;
    logic [7:0] chk_xor;
    bit         exp_done;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] img_sum();
    int s = 0;
    for (int k = 0; k < NW; k++) s = (s + int'(img[k][15:8]) + int'(img[k][7:0])) % 256;
    return 8'(s);
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < NW; k++) img[k] = {8'(k), 8'(8'hA0 + k)};
  endtask

  task automatic fill_random();
    for (int k = 0; k < NW; k++) img[k] = 16'($urandom);
  endtask

  // Called and returns at a falling edge; the byte is consumed by the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input string tag);
    int budget = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (bus.byte_ready !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL %s:byte_timeout: byte_ready stayed low, expected high within 64 cycles", tag);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [7:0] chk, input bit gaps,
                          input bit poke, input bit exp_done);
    wr_q.delete();
    pulse_start();
    check({tag, ":start_cpu_rstn"}, 32'(bus.cpu_rstn), 0);
    check({tag, ":start_done"},     32'(bus.done), 0);
    check({tag, ":start_err"},      32'(bus.err), 0);
    check({tag, ":start_busy"},     32'(bus.busy), 1);
    for (int k = 0; k < NW; k++) begin
      send_byte(img[k][15:8], gaps, tag);
      if (poke && k == 3) begin
        pulse_start();
        check({tag, ":poke_rxlo_busy"}, 32'(bus.busy), 1);
      end
      send_byte(img[k][7:0], gaps, tag);
    end
    if (poke) begin
      @(negedge clk);
      pulse_start();
      check({tag, ":poke_check_ready"}, 32'(bus.byte_ready), 1);
    end
    send_byte(chk, gaps, tag);
    check({tag, ":writes"}, 32'(wr_q.size()), NW);
    for (int k = 0; k < NW && k < wr_q.size(); k++) begin
      check($sformatf("%s:addr%0d", tag, k), 32'(wr_q[k].addr), 32'(k));
      check($sformatf("%s:data%0d", tag, k), 32'(wr_q[k].data), 32'(img[k]));
    end
    check({tag, ":done"},       32'(bus.done), 32'(exp_done));
    check({tag, ":err"},        32'(bus.err), 32'(!exp_done));
    check({tag, ":cpu_rstn"},   32'(bus.cpu_rstn), 32'(exp_done));
    check({tag, ":busy_end"},   32'(bus.busy), 0);
    check({tag, ":ready_end"},  32'(bus.byte_ready), 0);
    check({tag, ":addr_hold"},  32'(bus.mem_addr), NW - 1);
    check({tag, ":wdata_hold"}, 32'(bus.mem_wdata), 32'(img[NW-1]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] chk;
    bit         exp_done;

    tbl[0] = '{"ramp_good",        1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{"ramp_bad",         1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[2] = '{"ramp_gaps",        1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{"ramp_start_poke",  1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[4] = '{"ramp_reload_done", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{"rand_bad_gaps",    1'b1, 1'b1, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{"rand_good",        1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    #22;
    check("rst_cpu_rstn", 32'(bus.cpu_rstn),   0);
    check("rst_ready",    32'(bus.byte_ready), 0);
    check("rst_we",       32'(bus.mem_we),     0);
    check("rst_busy",     32'(bus.busy),       0);
    check("rst_done",     32'(bus.done),       0);
    check("rst_err",      32'(bus.err),        0);
    check("rst_addr",     32'(bus.mem_addr),   0);
    check("rst_wdata",    32'(bus.mem_wdata),  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].random_img) fill_random();
      else fill_ramp();
      chk = (8'h00 - img_sum()) ^ tbl[i].chk_xor;
      run_load(tbl[i].name, chk, tbl[i].gaps, tbl[i].poke, tbl[i].exp_done);
      @(negedge clk);
    end

    // Abort after word 7 has been written, then recover with a full load.
    fill_ramp();
    wr_q.delete();
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(img[k][15:8], 1'b0, "abort");
      send_byte(img[k][7:0], 1'b0, "abort");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort:cpu_rstn", 32'(bus.cpu_rstn),   0);
    check("abort:busy",     32'(bus.busy),       0);
    check("abort:ready",    32'(bus.byte_ready), 0);
    check("abort:addr",     32'(bus.mem_addr),   0);
    @(negedge clk);
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h5A;
    repeat (6) @(negedge clk);
    bus.byte_valid = 1'b0;
    check("abort:writes",   32'(wr_q.size()),  8);
    check("abort:cpu_hold", 32'(bus.cpu_rstn), 0);
    check("abort:done",     32'(bus.done),     0);
    run_load("after_abort", 8'h00 - img_sum(), 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill_random();
      chk      = ($urandom_range(0, 1) == 1) ? (8'h00 - img_sum()) : 8'($urandom);
      exp_done = ((int'(img_sum()) + int'(chk)) % 256) == 0;
      run_load($sformatf("rand%0d", i), chk, $urandom_range(0, 1) == 1, 1'b0, exp_done);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
